// File: rtl/bsg_nor3_share_rr.sv
// ---------------------------------------------------------------------------
// bsg_nor3 / bsg_nor3_share_rr
//
// Purpose:
//   bsg_nor3 is a width_p-bit three-input NOR row.  With harden_p=1 it is
//   built as an explicit per-bit gate row so a hardened cell can be mapped
//   onto each bit.  With harden_p=0 it is a plain vector expression.
//
//   bsg_nor3_share_rr time-shares one bsg_nor3 row among els_p requesters.
//   A round-robin arbiter picks one valid requester per cycle while the
//   one-entry output slot is free (empty, or being drained this cycle).  The
//   winner's operands go through a one-hot mux into the NOR row, and the
//   result is registered together with the winner's index.
//
// Ports (bsg_nor3_share_rr):
//   clk_i    in   1                 clock
//   reset_i  in   1                 synchronous active-high reset
//   v_i      in   els_p             per-requester valid
//   a_i      in   els_p*width_p     operand A, requester k at [k*width_p +: width_p]
//   b_i      in   els_p*width_p     operand B, same packing
//   c_i      in   els_p*width_p     operand C, same packing
//   yumi_o   out  els_p             one-hot grant, operands consumed this cycle
//   v_o      out  1                 output slot holds a valid result
//   data_o   out  width_p           registered ~(a|b|c) of the granted triple
//   id_o     out  id_width_lp       index of the requester that produced data_o
//   yumi_i   in   1                 consumer takes data_o/id_o this cycle
//
// Ports (bsg_nor3):
//   a_i, b_i, c_i  in   width_p     operands
//   o              out  width_p     ~(a_i | b_i | c_i)
//
// width_p is expected to be 1..34 when harden_p=1 (the range of the hardened
// gate row); els_p must be at least 1.
// ---------------------------------------------------------------------------

module bsg_nor3 #(
  parameter int width_p  = 1,
  parameter bit harden_p = 1'b0
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic [width_p-1:0] c_i,
  output logic [width_p-1:0] o
);

  // The hardened flavour is written bit by bit so that each bit is its own
  // gate instance a placement flow can swap for a hard cell; logically both
  // branches compute the same function.
  if (harden_p) begin : g_hard
    for (genvar i = 0; i < width_p; i++) begin : g_bit
      assign o[i] = ~(a_i[i] | b_i[i] | c_i[i]);
    end
  end else begin : g_soft
    assign o = ~(a_i | b_i | c_i);
  end

endmodule


module bsg_nor3_share_rr #(
  parameter int width_p  = 8,
  parameter int els_p    = 4,
  parameter int harden_p = 0,
  localparam int id_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   a_i,
  input  logic [els_p*width_p-1:0]   b_i,
  input  logic [els_p*width_p-1:0]   c_i,
  output logic [els_p-1:0]           yumi_o,

  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [id_width_lp-1:0]     id_o,
  input  logic                       yumi_i
);

  logic                   slot_free;
  logic                   any_v;
  logic                   grant_v;
  logic [id_width_lp-1:0] ptr_r;
  logic [id_width_lp-1:0] winner;
  logic [els_p-1:0]       winner_oh;
  logic                   arb_found;
  logic [width_p-1:0]     sel_a;
  logic [width_p-1:0]     sel_b;
  logic [width_p-1:0]     sel_c;
  logic [width_p-1:0]     nor_o;

  // The slot can take a new result when it is empty or when the consumer is
  // draining it this very cycle, which gives one result per cycle.
  assign slot_free = ~v_o | yumi_i;
  assign any_v     = |v_i;
  assign grant_v   = slot_free & any_v & ~reset_i;

  // Round-robin search: walk upward from the pointer, wrapping past
  // els_p-1, and take the first requester with v_i set.  The walk is done
  // on an integer index so non-power-of-two els_p wraps correctly.  With
  // els_p=1 this collapses to "requester 0 if valid".
  always_comb begin
    winner    = '0;
    winner_oh = '0;
    arb_found = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      int idx;
      idx = int'(ptr_r) + i;
      if (idx >= els_p) begin
        idx = idx - els_p;
      end
      if (!arb_found && v_i[idx]) begin
        arb_found      = 1'b1;
        winner         = id_width_lp'(idx);
        winner_oh[idx] = 1'b1;
      end
    end
  end

  // Grants only go out when the slot can accept them and never during reset.
  assign yumi_o = grant_v ? winner_oh : '0;

  // One-hot AND-OR mux selecting the winner's operand slices.  It is driven
  // by the ungated one-hot so the mux does not depend on slot state; the
  // result is only captured when a grant actually happens.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int k = 0; k < els_p; k++) begin
      if (winner_oh[k]) begin
        sel_a = sel_a | a_i[k*width_p +: width_p];
        sel_b = sel_b | b_i[k*width_p +: width_p];
        sel_c = sel_c | c_i[k*width_p +: width_p];
      end
    end
  end

  // The single shared NOR row, fed straight from the mux.
  bsg_nor3 #(
    .width_p  (width_p),
    .harden_p (harden_p != 0)
  ) nor3 (
    .a_i (sel_a),
    .b_i (sel_b),
    .c_i (sel_c),
    .o   (nor_o)
  );

  // Output slot and round-robin pointer.  A grant refills the slot and moves
  // priority to the requester just after the winner.  A drain without a
  // grant only clears the valid; data and id keep their last values.  When
  // the slot is full and not drained everything holds.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_o    <= 1'b0;
      data_o <= '0;
      id_o   <= '0;
      ptr_r  <= '0;
    end else if (grant_v) begin
      v_o    <= 1'b1;
      data_o <= nor_o;
      id_o   <= winner;
      if (winner == id_width_lp'(els_p - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= winner + id_width_lp'(1);
      end
    end else if (yumi_i) begin
      v_o <= 1'b0;
    end
  end

  // The consumer may only take a result that is actually there.
  yumi_without_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o)
  );

  // At most one requester is granted in any cycle.
  yumi_onehot: assert property (
    @(posedge clk_i) $onehot0(yumi_o)
  );

endmodule

// File: tb/tb_bsg_nor3_share_rr.sv
// ---------------------------------------------------------------------------
// tb_bsg_nor3_share_rr
//
// Directed bench for bsg_nor3_share_rr.  The main instance is width_p=8,
// els_p=4.  Four further instances (width 1/17/34 hardened, width 40 soft,
// each with two requesters) share one stimulus loop of random triples.
// Inputs change on the falling edge; outputs are sampled there too, and the
// combinational grant is sampled 1 time unit after the inputs change.
// ---------------------------------------------------------------------------

module tb_bsg_nor3_share_rr;

  logic        clk;
  logic        reset;
  logic [3:0]  v;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic [3:0]  yumi_o;
  logic        v_o;
  logic [7:0]  data_o;
  logic [1:0]  id_o;
  logic        yumi_i;

  int n_checks;
  int n_fail;

  logic [1:0]  sw_v;
  logic        sw_yumi;

  logic [1:0]  s1_a, s1_b, s1_c, s1_yumi;
  logic        s1_v;
  logic [0:0]  s1_data;
  logic [0:0]  s1_id;

  logic [33:0] s17_a, s17_b, s17_c;
  logic [1:0]  s17_yumi;
  logic        s17_v;
  logic [16:0] s17_data;
  logic [0:0]  s17_id;

  logic [67:0] s34_a, s34_b, s34_c;
  logic [1:0]  s34_yumi;
  logic        s34_v;
  logic [33:0] s34_data;
  logic [0:0]  s34_id;

  logic [79:0] s40_a, s40_b, s40_c;
  logic [1:0]  s40_yumi;
  logic        s40_v;
  logic [39:0] s40_data;
  logic [0:0]  s40_id;

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bsg_nor3_share_rr #(.width_p(8), .els_p(4), .harden_p(0)) dut (
    .clk_i(clk), .reset_i(reset), .v_i(v), .a_i(a), .b_i(b), .c_i(c),
    .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .id_o(id_o), .yumi_i(yumi_i)
  );

  bsg_nor3_share_rr #(.width_p(1), .els_p(2), .harden_p(1)) sw1 (
    .clk_i(clk), .reset_i(reset), .v_i(sw_v), .a_i(s1_a), .b_i(s1_b), .c_i(s1_c),
    .yumi_o(s1_yumi), .v_o(s1_v), .data_o(s1_data), .id_o(s1_id), .yumi_i(sw_yumi)
  );

  bsg_nor3_share_rr #(.width_p(17), .els_p(2), .harden_p(1)) sw17 (
    .clk_i(clk), .reset_i(reset), .v_i(sw_v), .a_i(s17_a), .b_i(s17_b), .c_i(s17_c),
    .yumi_o(s17_yumi), .v_o(s17_v), .data_o(s17_data), .id_o(s17_id), .yumi_i(sw_yumi)
  );

  bsg_nor3_share_rr #(.width_p(34), .els_p(2), .harden_p(1)) sw34 (
    .clk_i(clk), .reset_i(reset), .v_i(sw_v), .a_i(s34_a), .b_i(s34_b), .c_i(s34_c),
    .yumi_o(s34_yumi), .v_o(s34_v), .data_o(s34_data), .id_o(s34_id), .yumi_i(sw_yumi)
  );

  bsg_nor3_share_rr #(.width_p(40), .els_p(2), .harden_p(0)) sw40 (
    .clk_i(clk), .reset_i(reset), .v_i(sw_v), .a_i(s40_a), .b_i(s40_b), .c_i(s40_c),
    .yumi_o(s40_yumi), .v_o(s40_v), .data_o(s40_data), .id_o(s40_id), .yumi_i(sw_yumi)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive the main instance's valids and consumer handshake on the falling
  // edge, then settle so the combinational grant can be sampled.
  task automatic applyStimulus(input logic [3:0] v_in, input logic yumi_in);
    @(negedge clk);
    v      = v_in;
    yumi_i = yumi_in;
    #1;
  endtask

  // Check the registered slot of the main instance.
  task automatic checkSlot(input string tag, input logic exp_v, input logic [1:0] exp_id,
                           input logic [7:0] exp_data);
    checkOutput({tag, " v_o"}, 64'(v_o), 64'(exp_v));
    checkOutput({tag, " id_o"}, 64'(id_o), 64'(exp_id));
    checkOutput({tag, " data_o"}, 64'(data_o), 64'(exp_data));
  endtask

  // Expected NOR per slice of the main operands below:
  // s0 ~01=FE, s1 ~10=EF, s2 ~(01|02|04)=F8, s3 ~(80|40|20)=1F.
  logic [7:0] exp_data [4];
  int         rr_ids   [6];

  initial begin
    logic [63:0] r;
    logic [39:0] ra, rb, rc, oa, ob, oc, e;
    logic        sel;

    n_checks = 0;
    n_fail   = 0;
    exp_data = '{8'hFE, 8'hEF, 8'hF8, 8'h1F};
    rr_ids   = '{2, 3, 0, 1, 2, 3};

    reset   = 1'b1;
    v       = 4'b0000;
    yumi_i  = 1'b0;
    a       = {8'h80, 8'h01, 8'h10, 8'h01};
    b       = {8'h40, 8'h02, 8'h00, 8'h00};
    c       = {8'h20, 8'h04, 8'h00, 8'h00};
    sw_v    = 2'b00;
    sw_yumi = 1'b0;
    s1_a = '0;  s1_b = '0;  s1_c = '0;
    s17_a = '0; s17_b = '0; s17_c = '0;
    s34_a = '0; s34_b = '0; s34_c = '0;
    s40_a = '0; s40_b = '0; s40_c = '0;

    repeat (2) @(posedge clk);

    // Reset state, and no grants while reset is high even with all valid.
    applyStimulus(4'b1111, 1'b0);
    checkSlot("reset", 1'b0, 2'd0, 8'h00);
    checkOutput("reset yumi_o", 64'(yumi_o), 64'h0);
    reset = 1'b0;
    v     = 4'b0000;

    // Single beat from requester 2.
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single yumi_o", 64'(yumi_o), 64'b0100);

    // Result appears; pointer is now 3, so only requester 1 valid wraps to it.
    applyStimulus(4'b0010, 1'b1);
    checkSlot("single", 1'b1, 2'd2, 8'hF8);
    checkOutput("wrap yumi_o", 64'(yumi_o), 64'b0010);

    // Pointer became 2 after granting 1; all requesting then rotates 2,3,0,1,2,3.
    applyStimulus(4'b1111, 1'b1);
    checkSlot("wrap", 1'b1, 2'd1, 8'hEF);
    checkOutput("rr0 yumi_o", 64'(yumi_o), 64'(4'b0001 << rr_ids[0]));
    for (int j = 1; j < 6; j++) begin
      applyStimulus(4'b1111, 1'b1);
      checkSlot($sformatf("rr%0d", j - 1), 1'b1, 2'(rr_ids[j-1]), exp_data[rr_ids[j-1]]);
      checkOutput($sformatf("rr%0d yumi_o", j), 64'(yumi_o), 64'(4'b0001 << rr_ids[j]));
    end

    // Backpressure: slot full with id 3, no drain for 5 cycles.
    for (int j = 0; j < 5; j++) begin
      applyStimulus(4'b0011, 1'b0);
      checkSlot($sformatf("hold%0d", j), 1'b1, 2'd3, 8'h1F);
      checkOutput($sformatf("hold%0d yumi_o", j), 64'(yumi_o), 64'h0);
    end

    // Drain releases the slot and requester 0 (pointer 0) wins the same cycle.
    applyStimulus(4'b0011, 1'b1);
    checkSlot("release", 1'b1, 2'd3, 8'h1F);
    checkOutput("release yumi_o", 64'(yumi_o), 64'b0001);

    // Pointer 1, only requester 3 valid: grant 3.
    applyStimulus(4'b1000, 1'b1);
    checkSlot("after release", 1'b1, 2'd0, 8'hFE);
    checkOutput("skip yumi_o", 64'(yumi_o), 64'b1000);

    // Slot holds id 3, consumer stalls, reset pulses for one cycle.
    applyStimulus(4'b1111, 1'b0);
    checkSlot("pre-reset", 1'b1, 2'd3, 8'h1F);
    reset = 1'b1;
    #1;
    checkOutput("mid-reset yumi_o", 64'(yumi_o), 64'h0);

    applyStimulus(4'b1111, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("post-reset v_o", 64'(v_o), 64'h0);
    checkOutput("post-reset yumi_o", 64'(yumi_o), 64'b0001);

    applyStimulus(4'b0000, 1'b1);
    checkSlot("post-reset", 1'b1, 2'd0, 8'hFE);
    checkOutput("idle yumi_o", 64'(yumi_o), 64'h0);

    applyStimulus(4'b0000, 1'b0);
    checkOutput("drained v_o", 64'(v_o), 64'h0);

    // Width sweep: one random requester per beat, other slice random too.
    for (int beat = 0; beat < 8; beat++) begin
      @(negedge clk);
      r = {$urandom(), $urandom()}; ra = r[39:0];
      r = {$urandom(), $urandom()}; rb = r[39:0];
      r = {$urandom(), $urandom()}; rc = r[39:0];
      r = {$urandom(), $urandom()}; oa = r[39:0];
      r = {$urandom(), $urandom()}; ob = r[39:0];
      r = {$urandom(), $urandom()}; oc = r[39:0];
      sel     = 1'($urandom_range(0, 1));
      sw_v    = sel ? 2'b10 : 2'b01;
      sw_yumi = 1'b0;
      e       = ~(ra | rb | rc);
      s1_a  = sel ? {ra[0:0],  oa[0:0]}  : {oa[0:0],  ra[0:0]};
      s1_b  = sel ? {rb[0:0],  ob[0:0]}  : {ob[0:0],  rb[0:0]};
      s1_c  = sel ? {rc[0:0],  oc[0:0]}  : {oc[0:0],  rc[0:0]};
      s17_a = sel ? {ra[16:0], oa[16:0]} : {oa[16:0], ra[16:0]};
      s17_b = sel ? {rb[16:0], ob[16:0]} : {ob[16:0], rb[16:0]};
      s17_c = sel ? {rc[16:0], oc[16:0]} : {oc[16:0], rc[16:0]};
      s34_a = sel ? {ra[33:0], oa[33:0]} : {oa[33:0], ra[33:0]};
      s34_b = sel ? {rb[33:0], ob[33:0]} : {ob[33:0], rb[33:0]};
      s34_c = sel ? {rc[33:0], oc[33:0]} : {oc[33:0], rc[33:0]};
      s40_a = sel ? {ra, oa} : {oa, ra};
      s40_b = sel ? {rb, ob} : {ob, rb};
      s40_c = sel ? {rc, oc} : {oc, rc};
      #1;
      checkOutput($sformatf("w1 b%0d yumi_o", beat),  64'(s1_yumi),  64'(sw_v));
      checkOutput($sformatf("w17 b%0d yumi_o", beat), 64'(s17_yumi), 64'(sw_v));
      checkOutput($sformatf("w34 b%0d yumi_o", beat), 64'(s34_yumi), 64'(sw_v));
      checkOutput($sformatf("w40 b%0d yumi_o", beat), 64'(s40_yumi), 64'(sw_v));

      @(negedge clk);
      sw_v = 2'b00;
      checkOutput($sformatf("w1 b%0d data_o", beat),  64'(s1_data),  64'(e[0:0]));
      checkOutput($sformatf("w17 b%0d data_o", beat), 64'(s17_data), 64'(e[16:0]));
      checkOutput($sformatf("w34 b%0d data_o", beat), 64'(s34_data), 64'(e[33:0]));
      checkOutput($sformatf("w40 b%0d data_o", beat), 64'(s40_data), 64'(e));
      checkOutput($sformatf("w40 b%0d id_o", beat),   64'(s40_id),   64'(sel));
      checkOutput($sformatf("w1 b%0d v_o", beat),     64'(s1_v),     64'h1);
      sw_yumi = 1'b1;

      @(negedge clk);
      sw_yumi = 1'b0;
      checkOutput($sformatf("w17 b%0d drained", beat), 64'(s17_v), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
